// File: rtl/deserializador_pkg.sv
// Shared types and defaults for the serial-to-parallel deserializer with output FIFO.
package deserializador_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned DEFAULT_DEPTH = 4;

  // Frame assembly state
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RECV = 2'd1,
    S_FULL = 2'd2
  } deser_state_e;

endpackage

// File: rtl/deser_fifo.sv
// Word storage for the deserializer: synchronous FIFO with occupancy count and full/empty flags.
// Pointers wrap explicitly at DEPTH-1, so DEPTH need not be a power of two.
module deser_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CntW  = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CntW-1:0]  count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned    PtrW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             full_q, full_d;
  logic             do_push, do_pop;

  assign do_push = push_i && !full_q;
  assign do_pop  = pop_i && (count_q != '0);

  // Next-state for pointers, occupancy and the registered full flag
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    full_d = (count_d == FullCnt);
  end

  // Control state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign empty_o = (count_q == '0);
  assign full_o  = full_q;
  assign count_o = count_q;
  // Head reads as zero when nothing is held
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/deserializador_fifo.sv
// Serial-to-parallel deserializer feeding a small word FIFO.
// Define DESER_PARITY_EN to append an even-parity bit to each frame; bad words are dropped
// and flagged on parity_err_out. Without it, parity_err_out is tied low.
module deserializador_fifo
  import deserializador_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter int unsigned DEPTH     = DEFAULT_DEPTH,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                       clock_100KHz,
  input  logic                       reset,
  input  logic                       write_in,
  input  logic                       data_in,
  input  logic                       ack_in,
  output logic                       status_out,
  output logic                       data_ready,
  output logic [WIDTH-1:0]           data_out,
  output logic [$clog2(DEPTH+1)-1:0] fill_out,
  output logic                       overrun_out,
  output logic                       parity_err_out
);

  localparam int unsigned FillW = $clog2(DEPTH + 1);
`ifdef DESER_PARITY_EN
  localparam int unsigned FrameLen = WIDTH + 1;
`else
  localparam int unsigned FrameLen = WIDTH;
`endif
  localparam int unsigned     CntW     = $clog2(FrameLen + 1);
  localparam logic [CntW-1:0] LastBit  = CntW'(FrameLen - 1);
  localparam logic [FillW:0]  FullFill = (FillW + 1)'(DEPTH);

  deser_state_e     state_q, state_d;
  logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             overrun_q, overrun_d;
`ifdef DESER_PARITY_EN
  logic             par_err_q, par_err_d;
`endif

  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] push_word;
  logic             push, pop, sample, last_bit;
  logic [FillW:0]   fill_next;
  logic [WIDTH-1:0] fifo_rdata;
  logic [FillW-1:0] fifo_count;
  logic             fifo_full, fifo_empty;

  assign pop = ack_in && !fifo_empty;

  // Frame assembly, push decision and FSM next state
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    overrun_d = overrun_q;
    push      = 1'b0;
    push_word = shift_q;
    sample    = 1'b0;
`ifdef DESER_PARITY_EN
    par_err_d = 1'b0;
`endif
    if (MSB_FIRST) begin
      shifted = {shift_q[WIDTH-2:0], data_in};
    end else begin
      shifted = {data_in, shift_q[WIDTH-1:1]};
    end

    unique case (state_q)
      S_IDLE: begin
        if (write_in) begin
          sample  = 1'b1;
          state_d = S_RECV;
        end
      end
      S_RECV: begin
        if (write_in) begin
          sample = 1'b1;
        end
      end
      S_FULL: begin
        // Serial input is refused; an offered bit only raises the sticky flag
        if (write_in) begin
          overrun_d = 1'b1;
        end
        if (pop) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    last_bit = sample && (bit_cnt_q == LastBit);

    if (sample) begin
      if (last_bit) begin
        bit_cnt_d = '0;
        shift_d   = '0;
`ifdef DESER_PARITY_EN
        // Final bit is the parity bit; the data word is already complete in shift_q
        push_word = shift_q;
        if ((^shift_q) != data_in) begin
          par_err_d = 1'b1;
        end else begin
          push = 1'b1;
        end
`else
        push_word = shifted;
        push      = 1'b1;
`endif
      end else begin
        bit_cnt_d = bit_cnt_q + CntW'(1);
        shift_d   = shifted;
      end
    end

    fill_next = {1'b0, fifo_count} + {{FillW{1'b0}}, push} - {{FillW{1'b0}}, pop};
    if (last_bit) begin
      state_d = (fill_next == FullFill) ? S_FULL : S_IDLE;
    end
  end

  // FSM and datapath registers
  always_ff @(posedge clock_100KHz or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      overrun_q <= 1'b0;
`ifdef DESER_PARITY_EN
      par_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      overrun_q <= overrun_d;
`ifdef DESER_PARITY_EN
      par_err_q <= par_err_d;
`endif
    end
  end

  deser_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .CntW  (FillW)
  ) u_fifo (
    .clk_i   (clock_100KHz),
    .rst_ni  (reset),
    .push_i  (push),
    .wdata_i (push_word),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign status_out  = fifo_full;
  assign data_ready  = !fifo_empty;
  assign data_out    = fifo_rdata;
  assign fill_out    = fifo_count;
  assign overrun_out = overrun_q;
`ifdef DESER_PARITY_EN
  assign parity_err_out = par_err_q;
`else
  assign parity_err_out = 1'b0;
`endif

endmodule

// File: tb/tb_deserializador_fifo.sv
// Self-checking bench for deserializador_fifo (WIDTH=8, DEPTH=4), plus an LSB-first instance.
module tb_deserializador_fifo;

`ifdef DESER_PARITY_EN
  localparam int FRAME = 9;
`else
  localparam int FRAME = 8;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       write_in, data_in, ack_in;
  logic       status, ready, overrun, perr;
  logic [7:0] dout;
  logic [2:0] fill;

  logic       w2, d2, a2;
  logic       status2, ready2, overrun2, perr2;
  logic [7:0] dout2;
  logic [2:0] fill2;

  deserializador_fifo #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b1)) dut (
    .clock_100KHz   (clk),
    .reset          (rst_n),
    .write_in       (write_in),
    .data_in        (data_in),
    .ack_in         (ack_in),
    .status_out     (status),
    .data_ready     (ready),
    .data_out       (dout),
    .fill_out       (fill),
    .overrun_out    (overrun),
    .parity_err_out (perr)
  );

  deserializador_fifo #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b0)) dut_lsb (
    .clock_100KHz   (clk),
    .reset          (rst_n),
    .write_in       (w2),
    .data_in        (d2),
    .ack_in         (a2),
    .status_out     (status2),
    .data_ready     (ready2),
    .data_out       (dout2),
    .fill_out       (fill2),
    .overrun_out    (overrun2),
    .parity_err_out (perr2)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] sbq[$];

  typedef struct {
    logic [7:0] word;
    logic [2:0] exp_fill;
    logic       exp_status;
  } vec_t;
  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends one frame MSB first; optional 2-cycle pause before bit pause_at and
  // an ack on the final bit (simultaneous push/pop).
  task automatic send_word(input logic [7:0] w, input int pause_at, input bit ack_last);
    logic b;
    for (int k = 0; k < FRAME; k++) begin
      if (k < 8) b = w[7-k];
      else b = ^w;
      if (pause_at != 0 && k == pause_at) begin
        for (int p = 0; p < 2; p++) begin
          write_in = 1'b0;
          data_in  = ~data_in;
          tick();
        end
      end
      if (ack_last && k == FRAME - 1) begin
        if (sbq.size() > 0) begin
          check("simul_head", {24'd0, dout}, {24'd0, sbq[0]});
          void'(sbq.pop_front());
        end
        ack_in = 1'b1;
      end
      write_in = 1'b1;
      data_in  = b;
      tick();
      write_in = 1'b0;
      ack_in   = 1'b0;
    end
    sbq.push_back(w);
  endtask

  task automatic pop_check(input string name);
    check({name, "_ready"}, {31'd0, ready}, 32'd1);
    if (sbq.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: got pop request, expected a queued word", name);
    end else begin
      check({name, "_data"}, {24'd0, dout}, {24'd0, sbq.pop_front()});
    end
    ack_in = 1'b1;
    tick();
    ack_in = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_status"}, {31'd0, status}, 32'd0);
    check({name, "_ready"}, {31'd0, ready}, 32'd0);
    check({name, "_data"}, {24'd0, dout}, 32'd0);
    check({name, "_fill"}, {29'd0, fill}, 32'd0);
    check({name, "_overrun"}, {31'd0, overrun}, 32'd0);
    check({name, "_perr"}, {31'd0, perr}, 32'd0);
  endtask

  // seq[7] is the first bit on the wire
  task automatic lsb_send(input logic [7:0] seq);
    for (int i = 7; i >= 0; i--) begin
      w2 = 1'b1;
      d2 = seq[i];
      tick();
    end
`ifdef DESER_PARITY_EN
    w2 = 1'b1;
    d2 = ^seq;
    tick();
`endif
    w2 = 1'b0;
  endtask

  initial begin
    write_in = 1'b0; data_in = 1'b0; ack_in = 1'b0;
    w2 = 1'b0; d2 = 1'b0; a2 = 1'b0;
    vecs[0] = '{word: 8'h01, exp_fill: 3'd1, exp_status: 1'b0};
    vecs[1] = '{word: 8'h02, exp_fill: 3'd2, exp_status: 1'b0};
    vecs[2] = '{word: 8'h03, exp_fill: 3'd3, exp_status: 1'b0};
    vecs[3] = '{word: 8'h04, exp_fill: 3'd4, exp_status: 1'b1};

    repeat (3) tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Basic frame, visible the cycle after the last bit
    send_word(8'hA5, 0, 1'b0);
    check("a5_fill", {29'd0, fill}, 32'd1);
    pop_check("a5");
    check("empty_data", {24'd0, dout}, 32'd0);
    check("empty_fill", {29'd0, fill}, 32'd0);

    // Pause with toggling data must not sample
    send_word(8'hA5, 3, 1'b0);
    check("pause_fill", {29'd0, fill}, 32'd1);
    pop_check("pause");

    // Fill to DEPTH from the table
    for (int i = 0; i < 4; i++) begin
      send_word(vecs[i].word, 0, 1'b0);
      check($sformatf("vec%0d_fill", i), {29'd0, fill}, {29'd0, vecs[i].exp_fill});
      check($sformatf("vec%0d_status", i), {31'd0, status}, {31'd0, vecs[i].exp_status});
    end

    // Offer bits while full
    write_in = 1'b1; data_in = 1'b1;
    tick(); tick();
    write_in = 1'b0;
    check("overrun_flag", {31'd0, overrun}, 32'd1);
    check("overrun_fill", {29'd0, fill}, 32'd4);
    check("overrun_status", {31'd0, status}, 32'd1);

    pop_check("full_pop");
    check("after_pop_head", {24'd0, dout}, 32'h02);
    check("after_pop_status", {31'd0, status}, 32'd0);
    check("after_pop_fill", {29'd0, fill}, 32'd3);

    send_word(8'h5A, 0, 1'b0);
    check("refill_status", {31'd0, status}, 32'd1);
    check("refill_fill", {29'd0, fill}, 32'd4);
    repeat (4) pop_check("drain");
    check("drained_fill", {29'd0, fill}, 32'd0);
    check("drained_ready", {31'd0, ready}, 32'd0);

    // Ack on empty buffer is ignored
    ack_in = 1'b1;
    tick();
    ack_in = 1'b0;
    check("ack_empty_fill", {29'd0, fill}, 32'd0);
    check("ack_empty_data", {24'd0, dout}, 32'd0);

    // Push and pop on the same edge
    send_word(8'h11, 0, 1'b0);
    send_word(8'h22, 0, 1'b1);
    check("simul_fill", {29'd0, fill}, 32'd1);
    pop_check("simul");

`ifdef DESER_PARITY_EN
    send_word(8'hA5, 0, 1'b0);
    check("par_ok_perr", {31'd0, perr}, 32'd0);
    check("par_ok_fill", {29'd0, fill}, 32'd1);
    for (int i = 7; i >= 0; i--) begin
      write_in = 1'b1;
      data_in  = 1'(8'hA5 >> i);
      tick();
    end
    write_in = 1'b1;
    data_in  = 1'b1;
    tick();
    write_in = 1'b0;
    check("par_bad_perr", {31'd0, perr}, 32'd1);
    check("par_bad_fill", {29'd0, fill}, 32'd1);
    tick();
    check("par_pulse_end", {31'd0, perr}, 32'd0);
    pop_check("par_ok");
`else
    send_word(8'hC3, 0, 1'b0);
    check("perr_tied", {31'd0, perr}, 32'd0);
    pop_check("c3");
`endif

    // Reset mid-frame; overrun is still set from earlier
    check("overrun_sticky", {31'd0, overrun}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      write_in = 1'b1;
      data_in  = 1'b1;
      tick();
    end
    write_in = 1'b0;
    rst_n = 1'b0;
    #2;
    check_all_zero("midreset");
    tick();
    rst_n = 1'b1;
    tick();
    send_word(8'h3C, 0, 1'b0);
    check("post_reset_fill", {29'd0, fill}, 32'd1);
    pop_check("post_reset");

    // LSB-first instance
    lsb_send(8'b1010_0101);
    check("lsb_a5_ready", {31'd0, ready2}, 32'd1);
    check("lsb_a5_data", {24'd0, dout2}, 32'hA5);
    a2 = 1'b1;
    tick();
    a2 = 1'b0;
    check("lsb_pop_fill", {29'd0, fill2}, 32'd0);
    lsb_send(8'b1100_0000);
    check("lsb_03_data", {24'd0, dout2}, 32'h03);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/deserializador_fifo.md
DESERIALIZADOR_FIFO -- requirements
Module: deserializador_fifo

Interface
REQ-001 Parameter WIDTH, default 8, bits per word (legal range 2..32).
REQ-002 Parameter DEPTH, default 4, output buffer entries (legal range 1..16).
REQ-003 Parameter MSB_FIRST, default 1: 1 means the first serial bit lands in data_out[WIDTH-1]; 0 means it lands in data_out[0].
REQ-004 clock_100KHz  in  1  sole clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 write_in  in  1  data_in is valid this cycle.
REQ-007 data_in  in  1  serial bit.
REQ-008 ack_in  in  1  consumer pops the head word.
REQ-009 status_out  out  1  buffer full; serial input is refused while it is 1.
REQ-010 data_ready  out  1  buffer non-empty; data_out is valid.
REQ-011 data_out  out  WIDTH  head word of the buffer; 0 when the buffer is empty.
REQ-012 fill_out  out  $clog2(DEPTH+1)  number of words currently held.
REQ-013 overrun_out  out  1  sticky flag: a bit was offered while full.
REQ-014 parity_err_out  out  1  one-cycle pulse: word rejected for bad parity.

Function
REQ-015 FSM states S_IDLE, S_RECV and S_FULL; the state variable uses a package enum.
REQ-016 In S_IDLE: bit count is 0 and the buffer is not full; write_in=1 samples the bit and moves to S_RECV.
REQ-017 In S_RECV: each cycle with write_in=1 samples one bit and increments the count; write_in=0 holds the count and the shift register with no timeout.
REQ-018 When the last bit of a frame is sampled, the word is pushed and the count clears in the same edge.
REQ-018a After that edge the FSM goes to S_FULL if fill_out reaches DEPTH, otherwise to S_IDLE.
REQ-019 Latency: the pushed word is visible on data_out with data_ready=1 in the first cycle after the edge that sampled the last bit, provided the buffer was empty.
REQ-020 Pop: ack_in=1 with data_ready=1 removes the head at the edge; the next word, or 0, appears the following cycle.
REQ-020a ack_in=1 with data_ready=0 is ignored.
REQ-021 A push and a pop on the same edge leave fill_out unchanged; words are delivered in FIFO order.
REQ-022 In S_FULL: status_out=1 and write_in is ignored.
REQ-022a In S_FULL, write_in=1 sets overrun_out=1 until reset.
REQ-022b A pop in S_FULL returns the FSM to S_IDLE on the next cycle.
REQ-023 status_out is registered and equals (fill_out==DEPTH).
REQ-024 Buffer pointers wrap modulo DEPTH; DEPTH need not be a power of two.

Reset
REQ-025 With reset=0: state=S_IDLE, count=0, shift register=0, buffer pointers=0, and fill_out=0.
REQ-025a With reset=0: every output is 0, including data_out and the overrun_out flag.
REQ-026 Reset asserted mid-frame discards the partial word; the next frame after release is assembled from bit 0.

Configuration
REQ-027 Macro DESER_PARITY_EN defined: each frame is WIDTH data bits followed by one even-parity bit.
REQ-027a With DESER_PARITY_EN, a parity mismatch drops the word (no push) and pulses parity_err_out for 1 cycle; a match pushes normally.
REQ-028 Macro DESER_PARITY_EN undefined: a frame is WIDTH bits and parity_err_out is tied to 0; the port is always present.

Structure
REQ-029 Package deserializador_pkg holds the state enum and DEFAULT_WIDTH=8 and DEFAULT_DEPTH=4.
REQ-030 Sub-module deser_fifo (parametrised WIDTH/DEPTH synchronous FIFO with count, full and empty) holds the word storage; the top holds the FSM and the shift register.

Verification (WIDTH=8, DEPTH=4, MSB_FIRST=1 unless noted)
REQ-031 Release reset, then drive bits 1,0,1,0,0,1,0,1 with write_in=1 -> next cycle: data_ready=1, data_out=8'hA5, fill_out=1.
REQ-032 Drive 3 bits, then write_in=0 for 2 cycles with data_in toggling, then 5 bits -> data_out=8'hA5 and the paused bits are not sampled.
REQ-033 Push 8'h01, 8'h02, 8'h03, 8'h04 with no ack -> status_out=1 and fill_out=4.
REQ-033a In that full state, drive write_in=1 -> overrun_out=1 and fill_out stays 4; then ack_in=1 for 1 cycle -> data_out=8'h02 and status_out=0.
REQ-034 Drive 5 bits, then pulse reset=0 -> all outputs 0; a following 8'h3C frame yields data_out=8'h3C.
REQ-035 MSB_FIRST=0: drive bits 1,0,1,0,0,1,0,1 -> data_out=8'hA5 bit-reversed, i.e. 8'hA5; also drive 1,1,0,0,0,0,0,0 -> data_out=8'h03.
REQ-036 DESER_PARITY_EN: 8'hA5 followed by parity 0 -> pushed; 8'hA5 followed by parity 1 -> parity_err_out pulses for 1 cycle and fill_out is unchanged.
